// File: rtl/mini_src_ctrl_pkg.sv
// Shared encodings for the Mini SRC hardwired control unit: opcodes, FSM states,
// bit positions inside the one-hot bus_src and reg_ld vectors, and ALU codes.
package mini_src_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_RST  = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_T7   = 4'd8,
    ST_HALT = 4'd9
  } state_e;

  localparam int unsigned MAX_WAIT_DEFAULT = 15;
  localparam logic [5:0]  ALU_SEL_ADD      = 6'd3;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int BS_PCOUT     = 0;
  localparam int BS_MDROUT    = 1;
  localparam int BS_ZHIGHOUT  = 2;
  localparam int BS_ZLOWOUT   = 3;
  localparam int BS_HIOUT     = 4;
  localparam int BS_LOOUT     = 5;
  localparam int BS_INPORTOUT = 6;
  localparam int BS_COUT      = 7;

  localparam int RL_PCIN      = 0;
  localparam int RL_IRIN      = 1;
  localparam int RL_MARIN     = 2;
  localparam int RL_MDRIN     = 3;
  localparam int RL_YIN       = 4;
  localparam int RL_ZIN       = 5;
  localparam int RL_HIIN      = 6;
  localparam int RL_LOIN      = 7;
  localparam int RL_OUTPORTIN = 8;
  localparam int RL_CONIN     = 9;

  function automatic logic is_alu_rr(input logic [4:0] op);
    return (op >= OP_ADD) && (op <= OP_ROL);
  endfunction

  function automatic logic is_alu_imm(input logic [4:0] op);
    return (op >= OP_ADDI) && (op <= OP_ORI);
  endfunction

endpackage

// File: rtl/mini_src_control_unit_mem_wait_timer.sv
// Counts cycles spent waiting for mem_done; flags a timeout on the cycle the
// count reaches MAX_WAIT without the handshake arriving.
module mem_wait_timer
  import mini_src_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic wait_i,
  input  logic done_i,
  output logic timeout_o
);

  logic [3:0] cnt_q, cnt_d;

  assign timeout_o = wait_i && !done_i && (cnt_q == 4'(MAX_WAIT));

  always_comb begin
    cnt_d = 4'd0;
    if (wait_i && !done_i && !timeout_o) cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 4'd0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mini_src_control_unit.sv
// Hardwired Moore control unit for the single-bus Mini SRC: fetch T0-T2, opcode
// dependent execute T3-T7, memory-done handshake with timeout, halt on request.
module mini_src_control_unit
  import mini_src_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        mem_done,
  input  logic        stop,
  output logic [7:0]  bus_src,
  output logic [9:0]  reg_ld,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        inc_pc,
  output logic        read,
  output logic        write,
  output logic [5:0]  alu_sel,
  output logic        run,
  output logic        illegal,
  output logic        mem_err
);

  state_e     state_q, state_d, last_st;
  logic       stop_q, stop_d;
  logic       mem_err_q, mem_err_d;
  logic       wait_step, last_step, timeout, run_st;
  logic [4:0] op;
  logic       unused_ir;

  assign op        = ir[31:27];
  assign unused_ir = ^ir[26:0];
  assign run_st    = (state_q != ST_RST) && (state_q != ST_HALT);
  assign run       = run_st;
  assign mem_err   = mem_err_q;

  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk       (clk),
    .rst       (clr),
    .wait_i    (wait_step),
    .done_i    (mem_done),
    .timeout_o (timeout)
  );

  always_comb begin
    wait_step = (state_q == ST_T1) || (state_q == ST_T6 && op == OP_LD) ||
                (state_q == ST_T7 && op == OP_ST);
    last_st = ST_T3;
    if (is_alu_rr(op) || is_alu_imm(op) || op == OP_LDI)  last_st = ST_T5;
    else if (op == OP_LD || op == OP_ST)                   last_st = ST_T7;
    else if (op == OP_MUL || op == OP_DIV || op == OP_BR)  last_st = ST_T6;
    else if (op == OP_NEG || op == OP_NOT || op == OP_JAL) last_st = ST_T4;
    last_step = (state_q == last_st);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= ST_RST;
      stop_q    <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stop_q    <= stop_d;
      mem_err_q <= mem_err_d;
    end
  end

  // A stop seen anywhere inside the instruction is honoured at its last step.
  always_comb begin
    state_d   = state_q;
    stop_d    = stop_q;
    mem_err_d = mem_err_q;
    if (run_st && stop) stop_d = 1'b1;
    case (state_q)
      ST_RST:  state_d = ST_T0;
      ST_HALT: state_d = ST_HALT;
      default: begin
        if (wait_step && !mem_done) begin
          if (timeout) begin
            state_d   = ST_HALT;
            mem_err_d = 1'b1;
          end
        end else if (state_q == ST_T3 && op == OP_HALT) begin
          state_d = ST_HALT;
        end else if (last_step) begin
          state_d = (stop_q || stop) ? ST_HALT : ST_T0;
          stop_d  = 1'b0;
        end else begin
          state_d = state_e'(state_q + 4'd1);
        end
      end
    endcase
  end

  always_comb begin
    bus_src = '0;
    reg_ld  = '0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    inc_pc  = 1'b0;
    read    = 1'b0;
    write   = 1'b0;
    alu_sel = '0;
    illegal = 1'b0;
    case (state_q)
      ST_T0: begin bus_src[BS_PCOUT] = 1'b1; reg_ld[RL_MARIN] = 1'b1; inc_pc = 1'b1; end
      ST_T1: begin read = 1'b1; reg_ld[RL_MDRIN] = 1'b1; end
      ST_T2: begin bus_src[BS_MDROUT] = 1'b1; reg_ld[RL_IRIN] = 1'b1; end
      ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
        if (is_alu_rr(op) || is_alu_imm(op)) begin
          case (state_q)
            ST_T3: begin Grb = 1'b1; Rout = 1'b1; reg_ld[RL_YIN] = 1'b1; end
            ST_T4: begin
              if (is_alu_imm(op)) bus_src[BS_COUT] = 1'b1;
              else begin Grc = 1'b1; Rout = 1'b1; end
              reg_ld[RL_ZIN] = 1'b1;
              alu_sel = {1'b0, op};
            end
            ST_T5:   begin bus_src[BS_ZLOWOUT] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            default: ;
          endcase
        end else begin
          case (op)
            OP_LD, OP_LDI, OP_ST: begin
              case (state_q)
                ST_T3: begin Grb = 1'b1; BAout = 1'b1; reg_ld[RL_YIN] = 1'b1; end
                ST_T4: begin bus_src[BS_COUT] = 1'b1; reg_ld[RL_ZIN] = 1'b1; alu_sel = ALU_SEL_ADD; end
                ST_T5: begin
                  bus_src[BS_ZLOWOUT] = 1'b1;
                  if (op == OP_LDI) begin Gra = 1'b1; Rin = 1'b1; end
                  else reg_ld[RL_MARIN] = 1'b1;
                end
                ST_T6: begin
                  reg_ld[RL_MDRIN] = 1'b1;
                  if (op == OP_ST) begin Gra = 1'b1; Rout = 1'b1; end
                  else read = 1'b1;
                end
                ST_T7: begin
                  if (op == OP_ST) write = 1'b1;
                  else begin bus_src[BS_MDROUT] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                end
                default: ;
              endcase
            end
            OP_MUL, OP_DIV: begin
              case (state_q)
                ST_T3: begin Gra = 1'b1; Rout = 1'b1; reg_ld[RL_YIN] = 1'b1; end
                ST_T4: begin Grb = 1'b1; Rout = 1'b1; reg_ld[RL_ZIN] = 1'b1; alu_sel = {1'b0, op}; end
                ST_T5: begin bus_src[BS_ZLOWOUT] = 1'b1; reg_ld[RL_LOIN] = 1'b1; end
                ST_T6: begin bus_src[BS_ZHIGHOUT] = 1'b1; reg_ld[RL_HIIN] = 1'b1; end
                default: ;
              endcase
            end
            OP_NEG, OP_NOT: begin
              if (state_q == ST_T3) begin
                Grb = 1'b1; Rout = 1'b1; reg_ld[RL_ZIN] = 1'b1; alu_sel = {1'b0, op};
              end else if (state_q == ST_T4) begin
                bus_src[BS_ZLOWOUT] = 1'b1; Gra = 1'b1; Rin = 1'b1;
              end
            end
            OP_BR: begin
              case (state_q)
                ST_T3: begin Gra = 1'b1; Rout = 1'b1; reg_ld[RL_CONIN] = 1'b1; end
                ST_T4: begin bus_src[BS_PCOUT] = 1'b1; reg_ld[RL_YIN] = 1'b1; end
                ST_T5: begin bus_src[BS_COUT] = 1'b1; reg_ld[RL_ZIN] = 1'b1; alu_sel = ALU_SEL_ADD; end
                ST_T6: if (con_ff) begin bus_src[BS_ZLOWOUT] = 1'b1; reg_ld[RL_PCIN] = 1'b1; end
                default: ;
              endcase
            end
            OP_JR:  if (state_q == ST_T3) begin Gra = 1'b1; Rout = 1'b1; reg_ld[RL_PCIN] = 1'b1; end
            OP_JAL: begin
              if (state_q == ST_T3) begin bus_src[BS_PCOUT] = 1'b1; Grb = 1'b1; Rin = 1'b1; end
              else if (state_q == ST_T4) begin Gra = 1'b1; Rout = 1'b1; reg_ld[RL_PCIN] = 1'b1; end
            end
            OP_IN:   if (state_q == ST_T3) begin bus_src[BS_INPORTOUT] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_OUT:  if (state_q == ST_T3) begin Gra = 1'b1; Rout = 1'b1; reg_ld[RL_OUTPORTIN] = 1'b1; end
            OP_MFHI: if (state_q == ST_T3) begin bus_src[BS_HIOUT] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_MFLO: if (state_q == ST_T3) begin bus_src[BS_LOOUT] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_NOP, OP_HALT: ;
            default: illegal = (state_q == ST_T3);
          endcase
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mini_src_control_unit.sv
// Directed bench for mini_src_control_unit: every control output is packed into
// one vector and compared step by step against hand-built expected vectors.
module tb_mini_src_control_unit;

  logic        clk = 1'b0;
  logic        clr, con_ff, mem_done, stop;
  logic [31:0] ir;
  logic [7:0]  bus_src;
  logic [9:0]  reg_ld;
  logic        Gra, Grb, Grc, Rin, Rout, BAout, inc_pc, read, write, run, illegal, mem_err;
  logic [5:0]  alu_sel;
  logic [35:0] obs;
  int          checks = 0;
  int          failures = 0;

  localparam logic [7:0] B_PC = 8'h01, B_MDR = 8'h02, B_ZH = 8'h04, B_ZL = 8'h08, B_C = 8'h80;
  localparam logic [9:0] R_PC = 10'h001, R_IR = 10'h002, R_MAR = 10'h004, R_MDR = 10'h008,
                         R_Y = 10'h010, R_Z = 10'h020, R_HI = 10'h040, R_LO = 10'h080,
                         R_CON = 10'h200;
  localparam logic [5:0] G_A = 6'b100000, G_B = 6'b010000, G_C = 6'b001000,
                         G_RIN = 6'b000100, G_ROUT = 6'b000010, G_BA = 6'b000001;

  always #5 clk = ~clk;

  mini_src_control_unit #(.MAX_WAIT(15)) dut (
    .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .mem_done(mem_done), .stop(stop),
    .bus_src(bus_src), .reg_ld(reg_ld), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
    .Rout(Rout), .BAout(BAout), .inc_pc(inc_pc), .read(read), .write(write),
    .alu_sel(alu_sel), .run(run), .illegal(illegal), .mem_err(mem_err)
  );

  assign obs = {bus_src, reg_ld, Gra, Grb, Grc, Rin, Rout, BAout, inc_pc, read, write,
                alu_sel, run, illegal, mem_err};

  function automatic logic [35:0] ex(input logic [7:0] b, input logic [9:0] r,
                                     input logic [5:0] g, input logic inc, input logic rd,
                                     input logic wr, input logic [5:0] alu, input logic rn,
                                     input logic il, input logic me);
    return {b, r, g, inc, rd, wr, alu, rn, il, me};
  endfunction

  function automatic logic [35:0] xr(input logic [7:0] b, input logic [9:0] r,
                                     input logic [5:0] g, input logic [5:0] alu);
    return ex(b, r, g, 1'b0, 1'b0, 1'b0, alu, 1'b1, 1'b0, 1'b0);
  endfunction

  task automatic chk(input string tag, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch();
    chk("fetch_T0", ex(B_PC, R_MAR, 6'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0));
    tick();
    chk("fetch_T1", ex(8'h00, R_MDR, 6'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0));
    tick();
    chk("fetch_T2", xr(B_MDR, R_IR, 6'b0, 6'd0));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1; ir = 32'h0; con_ff = 1'b0; mem_done = 1'b1; stop = 1'b0;
    tick(); tick();
    chk("reset_outputs", 36'h0);
    clr = 1'b0;
    ir = 32'h1989_0000;
    tick();

    // add R3,R1,R2
    fetch();
    chk("add_T3", xr(8'h00, R_Y, G_B | G_ROUT, 6'd0)); tick();
    chk("add_T4", xr(8'h00, R_Z, G_C | G_ROUT, 6'd3)); tick();
    chk("add_T5", xr(B_ZL, 10'h0, G_A | G_RIN, 6'd0)); tick();

    // ld with mem_done arriving on the fourth T6 cycle
    ir = 32'h0000_0000;
    fetch();
    chk("ld_T3", xr(8'h00, R_Y, G_B | G_BA, 6'd0)); tick();
    chk("ld_T4", xr(B_C, R_Z, 6'b0, 6'd3)); tick();
    chk("ld_T5", xr(B_ZL, R_MAR, 6'b0, 6'd0));
    mem_done = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("ld_T6_wait", ex(8'h00, R_MDR, 6'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0));
      tick();
    end
    mem_done = 1'b1;
    chk("ld_T6_done", ex(8'h00, R_MDR, 6'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0));
    tick();
    chk("ld_T7", xr(B_MDR, 10'h0, G_A | G_RIN, 6'd0)); tick();

    // br, not taken then taken
    ir = 32'h9800_0000;
    for (int k = 0; k < 2; k++) begin
      con_ff = (k == 1);
      fetch();
      chk("br_T3", xr(8'h00, R_CON, G_A | G_ROUT, 6'd0)); tick();
      chk("br_T4", xr(B_PC, R_Y, 6'b0, 6'd0)); tick();
      chk("br_T5", xr(B_C, R_Z, 6'b0, 6'd3)); tick();
      chk("br_T6", (k == 1) ? xr(B_ZL, R_PC, 6'b0, 6'd0) : xr(8'h00, 10'h0, 6'b0, 6'd0));
      tick();
    end
    con_ff = 1'b0;

    // mul with stop pulsed in T4: finishes, then halts
    ir = 32'h7800_0000;
    fetch();
    chk("mul_T3", xr(8'h00, R_Y, G_A | G_ROUT, 6'd0)); tick();
    chk("mul_T4", xr(8'h00, R_Z, G_B | G_ROUT, 6'd15));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("mul_T5", xr(B_ZL, R_LO, 6'b0, 6'd0)); tick();
    chk("mul_T6", xr(B_ZH, R_HI, 6'b0, 6'd0)); tick();
    chk("mul_halt", 36'h0); tick();
    chk("mul_halt_hold", 36'h0);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_after_halt", 36'h0);
    ir = 32'hF000_0000;
    tick();

    // undefined opcode 11110
    fetch();
    chk("illegal_T3", ex(8'h00, 10'h0, 6'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b1, 1'b0));
    tick();

    // memory timeout in T1
    ir = 32'hD000_0000;
    chk("tmo_T0", ex(B_PC, R_MAR, 6'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0));
    mem_done = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("tmo_T1_read", ex(8'h00, R_MDR, 6'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0));
      tick();
    end
    chk("tmo_halt", ex(8'h00, 10'h0, 6'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1));
    tick();
    chk("tmo_halt_hold", ex(8'h00, 10'h0, 6'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1));

    // clear, then reset asynchronously in the middle of an ld T6 wait
    #2 clr = 1'b1;
    #1 chk("clr_clears_err", 36'h0);
    tick();
    clr = 1'b0; mem_done = 1'b1; ir = 32'h0000_0000;
    tick();
    fetch();
    tick(); tick();
    mem_done = 1'b0;
    tick();
    chk("ld2_T6", ex(8'h00, R_MDR, 6'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0));
    #2 clr = 1'b1;
    #1 chk("async_clr_midwait", 36'h0);
    tick();
    clr = 1'b0; mem_done = 1'b1;
    chk("rst_after_clr", 36'h0);
    tick();
    chk("T0_after_clr", ex(B_PC, R_MAR, 6'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
